// File: rtl/wb_daq_sram_writer_if.sv
// Wishbone classic master/slave signal bundle used by wb_daq_sram_writer.
// The master drives address, data, select and strobes; the slave returns ack/err.
interface wb_daq_sram_writer_if #(
    parameter int dw = 32
);
    logic [31:0]   wb_adr_o;
    logic [dw-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_ack_i;
    logic          wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_daq_sram_writer.sv
// DAQ channel SRAM responder: grants one word, writes it to a circular Wishbone buffer.
// Optional bus watchdog enabled by defining WB_DAQ_SRAM_WRITER_TIMEOUT_EN.
module wb_daq_sram_writer #(
    parameter int dw = 32,
    parameter int aw = 16
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [31:0]          base_address,
    input  logic [aw-1:0]        length,
    input  logic                 start_sram,
    input  logic [dw-1:0]        data_in,
    output logic                 grant,
    output logic                 data_done,
    output logic [aw-1:0]        write_pointer,
    output logic                 wrapped,
    output logic                 bus_error,
    wb_daq_sram_writer_if.master wb
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LATCH,
        BUS,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          data_done_q, data_done_d;
    logic [31:0]   adr_q, adr_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          strobe_q, strobe_d;
    logic [aw-1:0] ptr_q, ptr_d;
    logic          wrapped_q, wrapped_d;
    logic          bus_error_q, bus_error_d;
    logic          bus_timeout;
    logic          ptr_at_end;

`ifdef WB_DAQ_SRAM_WRITER_TIMEOUT_EN
    logic [7:0]    timer_q, timer_d;

    // Fires on the 256th BUS cycle without a slave termination.
    assign bus_timeout = (timer_q == 8'hFF);
`else
    assign bus_timeout = 1'b0;
`endif

    // A zero length mid-transfer, or a pointer beyond a shrunk buffer, folds back to 0.
    assign ptr_at_end = (length == '0) || (ptr_q >= (length - aw'(1)));

    always_comb begin
        state_d     = state_q;
        grant_d     = 1'b0;
        data_done_d = 1'b0;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        strobe_d    = strobe_q;
        ptr_d       = ptr_q;
        wrapped_d   = wrapped_q;
        bus_error_d = bus_error_q;
`ifdef WB_DAQ_SRAM_WRITER_TIMEOUT_EN
        timer_d     = timer_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable && start_sram && (length != '0)) begin
                    state_d = GRANT;
                    grant_d = 1'b1;
                end
            end
            GRANT: begin
                state_d = LATCH;
            end
            LATCH: begin
                dat_d    = data_in;
                adr_d    = base_address + (32'(ptr_q) << 2);
                sel_d    = 4'hF;
                strobe_d = 1'b1;
                state_d  = BUS;
`ifdef WB_DAQ_SRAM_WRITER_TIMEOUT_EN
                timer_d  = 8'd0;
`endif
            end
            BUS: begin
                // err has priority over a simultaneous ack; the word is dropped.
                if (wb.wb_err_i || bus_timeout) begin
                    sel_d       = 4'h0;
                    strobe_d    = 1'b0;
                    bus_error_d = 1'b1;
                    data_done_d = 1'b1;
                    state_d     = DONE;
                end else if (wb.wb_ack_i) begin
                    sel_d       = 4'h0;
                    strobe_d    = 1'b0;
                    data_done_d = 1'b1;
                    state_d     = DONE;
                    if (ptr_at_end) begin
                        ptr_d     = '0;
                        wrapped_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + aw'(1);
                    end
                end else begin
`ifdef WB_DAQ_SRAM_WRITER_TIMEOUT_EN
                    timer_d = timer_q + 8'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                sel_d    = 4'h0;
                strobe_d = 1'b0;
            end
        endcase

        if (clear) begin
            ptr_d       = '0;
            wrapped_d   = 1'b0;
            bus_error_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            data_done_q <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            strobe_q    <= 1'b0;
            ptr_q       <= '0;
            wrapped_q   <= 1'b0;
            bus_error_q <= 1'b0;
`ifdef WB_DAQ_SRAM_WRITER_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            data_done_q <= data_done_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            strobe_q    <= strobe_d;
            ptr_q       <= ptr_d;
            wrapped_q   <= wrapped_d;
            bus_error_q <= bus_error_d;
`ifdef WB_DAQ_SRAM_WRITER_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign data_done     = data_done_q;
    assign write_pointer = ptr_q;
    assign wrapped       = wrapped_q;
    assign bus_error     = bus_error_q;
    assign wb.wb_adr_o   = adr_q;
    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_sel_o   = sel_q;
    assign wb.wb_we_o    = strobe_q;
    assign wb.wb_cyc_o   = strobe_q;
    assign wb.wb_stb_o   = strobe_q;

endmodule

// File: tb/tb_wb_daq_sram_writer.sv
// Self-checking bench for wb_daq_sram_writer: vector table of word transfers,
// a scoreboard of expected bus beats, and hand sequences for idle, reset and timeout cases.
module tb_wb_daq_sram_writer;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          wb_clk = 1'b0;
    logic          wb_rst;
    logic          enable;
    logic          clear_main;
    logic          clear_slave;
    logic          clear;
    logic [31:0]   base_address;
    logic [AW-1:0] length;
    logic          start_sram;
    logic [DW-1:0] data_in;
    logic          grant;
    logic          data_done;
    logic [AW-1:0] write_pointer;
    logic          wrapped;
    logic          bus_error;

    wb_daq_sram_writer_if #(.dw(DW)) wb_bus();

    assign clear = clear_main | clear_slave;

    wb_daq_sram_writer #(.dw(DW), .aw(AW)) dut (
        .wb_clk        (wb_clk),
        .wb_rst        (wb_rst),
        .enable        (enable),
        .clear         (clear),
        .base_address  (base_address),
        .length        (length),
        .start_sram    (start_sram),
        .data_in       (data_in),
        .grant         (grant),
        .data_done     (data_done),
        .write_pointer (write_pointer),
        .wrapped       (wrapped),
        .bus_error     (bus_error),
        .wb            (wb_bus)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [31:0]   adr;
        logic [DW-1:0] dat;
    } beat_t;

    // term: 0 = ack, 1 = err, 2 = ack and err together
    typedef struct {
        logic [DW-1:0] data;
        int            hold;
        int            term;
        bit            clr;
        logic [31:0]   adr;
        logic [AW-1:0] ptr;
        bit            wr;
        bit            be;
    } vec_t;

    beat_t sb_q[$];
    vec_t  vecs[13];

    int compared      = 0;
    int mismatched    = 0;
    int slave_hold    = 1;
    int slave_term    = 0;
    bit slave_never   = 1'b0;
    bit slave_clear   = 1'b0;
    int wait_cnt      = 0;
    int strobe_cycles = 0;
    int grant_count   = 0;
    int done_count    = 0;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // Slave model and monitor: terminates each cycle on its slave_hold-th strobe
    // cycle and compares the beat against the head of the scoreboard.
    always @(negedge wb_clk) begin
        beat_t exp_beat;
        if (grant) grant_count++;
        if (data_done) done_count++;
        clear_slave     = 1'b0;
        wb_bus.wb_ack_i = 1'b0;
        wb_bus.wb_err_i = 1'b0;
        if (wb_bus.wb_cyc_o && wb_bus.wb_stb_o) begin
            strobe_cycles++;
            wait_cnt++;
            if (!slave_never && wait_cnt == slave_hold) begin
                wb_bus.wb_ack_i = (slave_term != 1);
                wb_bus.wb_err_i = (slave_term != 0);
                clear_slave     = slave_clear;
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL sb_empty: got beat adr 0x%0h, expected none",
                             wb_bus.wb_adr_o);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check_output("beat_adr", 64'(wb_bus.wb_adr_o), 64'(exp_beat.adr));
                    check_output("beat_dat", 64'(wb_bus.wb_dat_o), 64'(exp_beat.dat));
                    check_output("beat_sel_we", {59'd0, wb_bus.wb_sel_o, wb_bus.wb_we_o},
                                 {59'd0, 4'hF, 1'b1});
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // One word transfer: request in cycle 0, data_in valid only in the cycle after
    // grant, returns grant/done cycle numbers, ends in the IDLE cycle after DONE.
    task automatic apply_stimulus(input vec_t v, output int grant_cycle,
                                  output int done_cycle);
        bit grant_prev;
        slave_hold  = v.hold;
        slave_term  = v.term;
        slave_clear = v.clr;
        slave_never = 1'b0;
        sb_q.push_back('{v.adr, v.data});
        grant_cycle = -1;
        done_cycle  = -1;
        grant_prev  = 1'b0;
        start_sram  = 1'b1;
        data_in     = ~v.data;
        for (int c = 1; c <= 400; c++) begin
            tick();
            data_in = grant_prev ? v.data : ~v.data;
            grant_prev = grant;
            if (grant) begin
                grant_cycle = c;
                start_sram  = 1'b0;
            end
            if (data_done) begin
                done_cycle = c;
                break;
            end
        end
        start_sram = 1'b0;
        tick();
    endtask

    task automatic run_vector(input int i);
        int gc;
        int dc;
        apply_stimulus(vecs[i], gc, dc);
        check_output($sformatf("v%0d_grant_cycle", i), 64'(gc), 64'd1);
        check_output($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(vecs[i].hold + 3));
        check_output($sformatf("v%0d_ptr", i), 64'(write_pointer), 64'(vecs[i].ptr));
        check_output($sformatf("v%0d_flags", i), {62'd0, wrapped, bus_error},
                     {62'd0, vecs[i].wr, vecs[i].be});
    endtask

    task automatic idle_check(input string name);
        int g0;
        int s0;
        g0 = grant_count;
        s0 = strobe_cycles;
        start_sram = 1'b1;
        repeat (100) tick();
        start_sram = 1'b0;
        check_output({name, "_grants"}, 64'(grant_count - g0), 64'd0);
        check_output({name, "_strobes"}, 64'(strobe_cycles - s0), 64'd0);
    endtask

    initial begin
        int g0;
        int d0;
        int s0;
        bit seen;

        vecs[0]  = '{32'h0000_00A0, 1, 0, 1'b0, 32'h1000, 16'd1, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_00A1, 1, 0, 1'b0, 32'h1004, 16'd2, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_00A2, 1, 0, 1'b0, 32'h1008, 16'd3, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_00A3, 1, 0, 1'b0, 32'h100C, 16'd0, 1'b1, 1'b0};
        vecs[4]  = '{32'hB000_0000, 2, 0, 1'b0, 32'h1000, 16'd1, 1'b0, 1'b0};
        vecs[5]  = '{32'hB000_0001, 1, 1, 1'b0, 32'h1004, 16'd1, 1'b0, 1'b1};
        vecs[6]  = '{32'hB000_0002, 1, 0, 1'b0, 32'h1004, 16'd2, 1'b0, 1'b1};
        vecs[7]  = '{32'hB000_0003, 7, 0, 1'b0, 32'h1008, 16'd3, 1'b0, 1'b1};
        vecs[8]  = '{32'hC000_0000, 3, 0, 1'b0, 32'h100C, 16'd0, 1'b1, 1'b1};
        vecs[9]  = '{32'hC000_0001, 1, 2, 1'b0, 32'h1000, 16'd0, 1'b1, 1'b1};
        vecs[10] = '{32'hC000_0002, 1, 0, 1'b0, 32'h1000, 16'd1, 1'b1, 1'b1};
        vecs[11] = '{32'hC000_0003, 1, 0, 1'b0, 32'h1004, 16'd2, 1'b1, 1'b1};
        vecs[12] = '{32'hC000_0004, 1, 0, 1'b1, 32'h1008, 16'd0, 1'b0, 1'b0};

        wb_rst       = 1'b0;
        enable       = 1'b0;
        clear_main   = 1'b0;
        start_sram   = 1'b0;
        data_in      = '0;
        base_address = 32'h0000_1000;
        length       = 16'd4;

        repeat (3) tick();
        check_output("rst_adr", 64'(wb_bus.wb_adr_o), 64'd0);
        check_output("rst_dat", 64'(wb_bus.wb_dat_o), 64'd0);
        check_output("rst_bus", {57'd0, wb_bus.wb_sel_o, wb_bus.wb_we_o, wb_bus.wb_cyc_o,
                                 wb_bus.wb_stb_o}, 64'd0);
        check_output("rst_flags", {60'd0, grant, data_done, wrapped, bus_error}, 64'd0);
        check_output("rst_ptr", 64'(write_pointer), 64'd0);

        wb_rst = 1'b1;
        tick();
        enable = 1'b1;

        $display("[TB] four-word fill with wrap");
        g0 = grant_count;
        d0 = done_count;
        for (int i = 0; i < 4; i++) run_vector(i);
        check_output("fill_grants", 64'(grant_count - g0), 64'd4);
        check_output("fill_dones", 64'(done_count - d0), 64'd4);

        clear_main = 1'b1;
        tick();
        clear_main = 1'b0;
        check_output("clear_state", {47'd0, write_pointer, wrapped},
                     {47'd0, 16'd0, 1'b0});

        $display("[TB] err, delayed ack, ack+err and clear-at-ack vectors");
        for (int i = 4; i < 13; i++) begin
            s0 = strobe_cycles;
            run_vector(i);
            check_output($sformatf("v%0d_strobes", i), 64'(strobe_cycles - s0),
                         64'(vecs[i].hold));
        end

        $display("[TB] disabled and zero-length requests");
        enable = 1'b0;
        idle_check("disabled");
        enable = 1'b1;
        length = 16'd0;
        idle_check("len_zero");
        length = 16'd4;

        $display("[TB] async reset during a bus cycle");
        slave_never = 1'b1;
        start_sram  = 1'b1;
        seen        = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (grant) start_sram = 1'b0;
            seen = wb_bus.wb_cyc_o;
        end
        start_sram = 1'b0;
        check_output("rst_wait_cyc", 64'(seen), 64'd1);
        #2 wb_rst = 1'b0;
        #1;
        check_output("async_rst_strobes", {61'd0, wb_bus.wb_cyc_o, wb_bus.wb_stb_o,
                                           wb_bus.wb_we_o}, 64'd0);
        tick();
        wb_rst = 1'b1;
        tick();

        $display("[TB] unresponsive slave");
        s0 = strobe_cycles;
        d0 = done_count;
        start_sram = 1'b1;
`ifdef WB_DAQ_SRAM_WRITER_TIMEOUT_EN
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick();
            if (grant) start_sram = 1'b0;
            seen = data_done;
        end
        start_sram = 1'b0;
        tick();
        check_output("to_done_seen", 64'(seen), 64'd1);
        check_output("to_strobes", 64'(strobe_cycles - s0), 64'd256);
        check_output("to_flags", {61'd0, bus_error, wb_bus.wb_cyc_o, wb_bus.wb_stb_o},
                     {61'd0, 1'b1, 1'b0, 1'b0});
        check_output("to_ptr", 64'(write_pointer), 64'd0);
`else
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (grant) start_sram = 1'b0;
        end
        start_sram = 1'b0;
        check_output("hang_strobes", {62'd0, wb_bus.wb_cyc_o, wb_bus.wb_stb_o}, 64'd3);
        check_output("hang_no_done", 64'(done_count - d0), 64'd0);
        check_output("hang_no_error", 64'(bus_error), 64'd0);
        wb_rst = 1'b0;
        tick();
        wb_rst = 1'b1;
        tick();
`endif
        slave_never = 1'b0;

        check_output("sb_leftover", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
